// File: rtl/fifo_drain.sv
// Read-side drain for a synchronous FIFO with one-cycle registered read data.
// Words are caught in a 2-entry skid buffer and presented on a valid/ready stream.
module fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_push,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  words_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] slot_q [2];
  logic                  rd_idx_q;
  logic                  wr_idx_q;
  logic                  inflight_q;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic [CNT_WIDTH-1:0]  words_q;
  logic [CNT_WIDTH-1:0]  words_d;
  logic                  xfer;
  logic                  room;

  assign xfer = m_valid && m_ready;

  // A word already in flight counts against capacity; a transfer this cycle frees a slot.
  assign room     = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2;
  assign fifo_pop = rst_n && en && !fifo_empty && !fifo_push && (room || xfer);

  assign occ_d   = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
  assign words_d = (xfer && (words_q != '1)) ? words_q + CNT_ONE : words_q;

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = slot_q[rd_idx_q];
  assign idle      = (occ_q == 2'd0) && !inflight_q;
  assign words_out = words_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      rd_idx_q   <= 1'b0;
      wr_idx_q   <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      words_q    <= '0;
    end else begin
      inflight_q <= fifo_pop;
      if (inflight_q) begin
        slot_q[wr_idx_q] <= fifo_data;
        wr_idx_q         <= ~wr_idx_q;
      end
      if (xfer) begin
        rd_idx_q <= ~rd_idx_q;
      end
      occ_q   <= occ_d;
      words_q <= words_d;
    end
  end

  occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

endmodule
